flash_mem_responder: RTL
========================

Name: flash_mem_responder

Overview:
- Responder side of the vproc data-memory interface: serves 32-bit word reads by issuing SPI READ (0x03) transactions to the external flash.
- Returns each word on rvalid/rdata. Writes and out-of-window addresses get an error response.
- Sits between the mmu's flash address window and the external_storage_spi_* pins. One transaction outstanding at a time.

Parameters:
- MEM_W, 32, data bus width in bits; only 32 is supported.
- CLK_DIV, 2, SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV).
- BASE_ADDR, 32'h0100_0000, flash window base; window spans 16 MiB (addr[31:24] must equal BASE_ADDR[31:24]).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low (asserted when 0)
- mem_req_i  input  1  request strobe
- mem_addr_i  input  32  byte address
- mem_we_i  input  1  1=write, 0=read
- mem_be_i  input  MEM_W/8  byte enables (ignored)
- mem_wdata_i  input  MEM_W  write data (ignored)
- mem_rvalid_o  output  1  one-cycle response strobe
- mem_err_o  output  1  error flag, valid with rvalid
- mem_rdata_o  output  MEM_W  read data, valid with rvalid
- spi_cs_n_o  output  1  flash chip select, active-low
- spi_sck_o  output  1  SPI clock, mode 0
- spi_mosi_o  output  1  data to flash
- spi_miso_i  input  1  data from flash

Behaviour:
- Reset values, asynchronous while rst=0:
  - spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0.
  - mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0.
  - State=IDLE.
- All outputs are registered.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, RESP.
- IDLE: mem_req_i=1 in cycle T is accepted. addr/we are latched. mem_req_i is ignored in every other state, with no queuing.
- Error path: accepted request with we=1 or addr[31:24]!=BASE_ADDR[31:24] goes IDLE -> RESP.
  - At T+1: rvalid=1, err=1, rdata=0.
  - No SPI activity.
- Valid read: the 64-bit frame shift register is loaded with {8'h03, addr[23:2], 2'b00, 32'h0}, sent MSB first.
- CS_SETUP: CLK_DIV cycles, cs_n=0, sck=0, mosi=frame bit 63.
- SHIFT: 64 bit periods, each 2*CLK_DIV cycles.
  - First CLK_DIV cycles: sck=0. Last CLK_DIV cycles: sck=1.
  - mosi holds the current frame bit for the whole period.
  - miso is sampled on the last cycle of the high phase into the LSB of the shift register, which shifts left.
  - Bits 31..0 captured during the data phase form 4 bytes. The first byte received goes to rdata[7:0], the fourth to rdata[31:24]; within each byte the first bit is the MSB.
- CS_HOLD: CLK_DIV cycles, sck=0, cs_n=0.
- RESP: one cycle, cs_n=1, rvalid=1, err=0, rdata=assembled word. Then back to IDLE.
  - A new request may be accepted in the cycle after RESP, which gives cs_n at least 1 high cycle between frames.
- Read latency: rvalid in cycle T+1+130*CLK_DIV (T+261 at CLK_DIV=2).
- mem_rvalid_o and mem_err_o are 0 outside RESP. mem_rdata_o holds its last value outside RESP.
- Address bits [1:0] are ignored for reads (word aligned).
- Reset asserted mid-transfer: cs_n rises immediately, no rvalid is produced for the aborted request, and the block restarts in IDLE.
- Bit and phase counters:
  - 6-bit bit counter with terminal count 63, so no wrap past 64.
  - Phase counter width $clog2(CLK_DIV)+1.

Decomposition:
- Package flash_mem_pkg holds:
  - FLASH_READ_CMD = 8'h03
  - FRAME_BITS = 64
  - state enum type flash_state_t
- One sub-module, spi_frame_shifter: parameterised by CLK_DIV. It generates sck phases, shifts a 64-bit frame out and in, and pulses done at the end of the last high phase.
- The top FSM owns request latching, the error path, cs_n and the response.

Test Plan:
- Read of addr 32'h0100_0104, flash model returning bytes 0xEF,0xBE,0xAD,0xDE:
  - MOSI frame must be 0x03,0x00,0x01,0x04.
  - rvalid at T+261 with rdata=32'hDEAD_BEEF, err=0.
  - Exactly 64 rising SCK edges while cs_n=0.
- Write to 32'h0100_0000:
  - rvalid=1, err=1, rdata=0 at T+1.
  - cs_n stays 1 and sck stays 0 throughout.
- Read of 32'h0200_0000 (outside window):
  - err=1 at T+1, no SPI activity.
- CLK_DIV=1, read of 32'h0100_0003:
  - Address phase sends 0x000000.
  - rvalid at T+131.
  - SCK toggles every clk cycle during SHIFT.
- req held high continuously for 3 consecutive reads:
  - Exactly 3 frames and 3 rvalid pulses, none overlapping.
  - Requests during busy are dropped.
  - cs_n is high for at least 1 cycle between frames.
- rst driven low at bit 40 of a frame:
  - cs_n=1, sck=0, rvalid=0 in the same cycle.
  - After release, the next read completes normally with correct data.

Source files
------------

// File: rtl/flash_mem_responder_pkg.sv
// Shared constants, FSM state type and byte-order helper for the flash read responder.
package flash_mem_pkg;

    localparam logic [7:0] FLASH_READ_CMD = 8'h03;
    localparam int         FRAME_BITS     = 64;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        RESP
    } flash_state_t;

    // The flash streams bytes in ascending address order; the first byte received
    // lands in the least significant byte of the word (little-endian memory view).
    function automatic logic [31:0] bytes_to_word(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/flash_mem_responder_if.sv
// Data-memory request/response bus between the vproc mmu window and the flash responder.
interface flash_mem_responder_if #(
    parameter int MEM_W = 32
);
    logic                 mem_req_i;
    logic [31:0]          mem_addr_i;
    logic                 mem_we_i;
    logic [MEM_W/8-1:0]   mem_be_i;
    logic [MEM_W-1:0]     mem_wdata_i;
    logic                 mem_rvalid_o;
    logic                 mem_err_o;
    logic [MEM_W-1:0]     mem_rdata_o;

    modport master (
        output mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
        input  mem_rvalid_o, mem_err_o, mem_rdata_o
    );

    modport slave (
        input  mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
        output mem_rvalid_o, mem_err_o, mem_rdata_o
    );
endinterface

// File: rtl/flash_mem_responder_shifter.sv
// SPI mode-0 frame engine: generates SCK phases, shifts a 64-bit frame out on MOSI
// and captures MISO into the same register, pulsing done at the end of the last high phase.
module spi_frame_shifter
    import flash_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] frame_in,
    input  logic        run,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [63:0] frame_out
);
    localparam int              PH_W    = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [5:0]      BIT_TC  = 6'(FRAME_BITS - 1);

    logic [PH_W-1:0] phase;
    logic            high;
    logic [5:0]      bit_cnt;
    logic [63:0]     sreg;
    logic            phase_end;
    logic            shift_now;

    assign phase_end = (phase == '0);
    assign shift_now = run && high && phase_end;
    assign done      = shift_now && (bit_cnt == BIT_TC);
    assign frame_out = sreg;

    // Phase down-counter, SCK level, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= '0;
            high    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (load) begin
            sreg    <= frame_in;
            mosi    <= frame_in[63];
            phase   <= PH_LAST;
            high    <= 1'b0;
            sck     <= 1'b0;
            bit_cnt <= '0;
        end else if (run) begin
            if (!phase_end) begin
                phase <= phase - 1'b1;
            end else begin
                phase <= PH_LAST;
                high  <= !high;
                sck   <= !high;
                if (high) begin
                    // Sample at the end of the high phase; MOSI moves on to the next bit
                    // and idles low once the final bit has gone out.
                    sreg <= {sreg[62:0], miso};
                    mosi <= (bit_cnt == BIT_TC) ? 1'b0 : sreg[62];
                    if (bit_cnt != BIT_TC) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/flash_mem_responder.sv
// Flash read responder: turns word reads in the flash window into SPI READ (0x03)
// frames and returns the assembled word; writes and out-of-window accesses get an error.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; accepts one and decides read vs error
// CS_SETUP | cs_n low, sck low, first MOSI bit presented for CLK_DIV cycles
// SHIFT    | 64 SCK periods shifting command/address out and data in
// CS_HOLD  | cs_n still low, sck low for CLK_DIV cycles after the last bit
// RESP     | one-cycle rvalid with err/rdata, cs_n high
module flash_mem_responder
    import flash_mem_pkg::*;
#(
    parameter int          MEM_W     = 32,
    parameter int          CLK_DIV   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    flash_mem_responder_if.slave  mem,
    output logic                  spi_cs_n_o,
    output logic                  spi_sck_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);
    localparam int              PH_W    = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    flash_state_t    state_q, state_d;
    logic [PH_W-1:0] timer_q, timer_d;
    logic            cs_n_q, cs_n_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic [MEM_W-1:0] rdata_q, rdata_d;

    logic            load;
    logic            run;
    logic            done;
    logic            req_bad;
    logic [63:0]     frame_in;
    logic [63:0]     frame_out;
    logic            unused_bits;

    assign req_bad  = mem.mem_we_i || (mem.mem_addr_i[31:24] != BASE_ADDR[31:24]);
    assign frame_in = {FLASH_READ_CMD, mem.mem_addr_i[23:2], 2'b00, 32'h0000_0000};

    // Byte enables, write data and the low address bits have no effect on a read-only window.
    assign unused_bits = ^{mem.mem_be_i, mem.mem_wdata_i, mem.mem_addr_i[1:0], frame_out[63:32]};

    spi_frame_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .frame_in  (frame_in),
        .run       (run),
        .miso      (spi_miso_i),
        .sck       (spi_sck_o),
        .mosi      (spi_mosi_o),
        .done      (done),
        .frame_out (frame_out)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cs_n_q   <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cs_n_q   <= cs_n_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state plus next values of the registered outputs (computed for the coming cycle).
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cs_n_d   = 1'b1;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        load     = 1'b0;
        run      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem.mem_req_i) begin
                    if (req_bad) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        timer_d = PH_LAST;
                        load    = 1'b1;
                    end
                end
            end
            CS_SETUP: begin
                cs_n_d = 1'b0;
                if (timer_q == '0) begin
                    state_d = SHIFT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                run    = 1'b1;
                if (done) begin
                    state_d = CS_HOLD;
                    timer_d = PH_LAST;
                end
            end
            CS_HOLD: begin
                if (timer_q == '0) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = bytes_to_word(frame_out[31:0]);
                end else begin
                    cs_n_d  = 1'b0;
                    timer_d = timer_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_cs_n_o       = cs_n_q;
    assign mem.mem_rvalid_o = rvalid_q;
    assign mem.mem_err_o    = err_q;
    assign mem.mem_rdata_o  = rdata_q;

endmodule
